// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states, opcodes,
// mux selects, the control-word struct and its Moore decoder.
package cu_pkg;

   localparam int unsigned STATE_W = 5;

   localparam logic [31:0] OVF_VECTOR = 32'd254;
   localparam logic [31:0] OPC_VECTOR = 32'd255;

   localparam logic [STATE_W-1:0] S_FETCH0    = 5'd0;
   localparam logic [STATE_W-1:0] S_FETCH1    = 5'd1;
   localparam logic [STATE_W-1:0] S_FETCH2    = 5'd2;
   localparam logic [STATE_W-1:0] S_DECODE    = 5'd3;
   localparam logic [STATE_W-1:0] S_R_EXEC    = 5'd4;
   localparam logic [STATE_W-1:0] S_R_WB      = 5'd5;
   localparam logic [STATE_W-1:0] S_ADDI_EXEC = 5'd6;
   localparam logic [STATE_W-1:0] S_ADDI_WB   = 5'd7;
   localparam logic [STATE_W-1:0] S_MEM_ADDR  = 5'd8;
   localparam logic [STATE_W-1:0] S_LW_RD0    = 5'd9;
   localparam logic [STATE_W-1:0] S_LW_RD1    = 5'd10;
   localparam logic [STATE_W-1:0] S_LW_WB     = 5'd11;
   localparam logic [STATE_W-1:0] S_SW_WR     = 5'd12;
   localparam logic [STATE_W-1:0] S_BRANCH    = 5'd13;
   localparam logic [STATE_W-1:0] S_JUMP      = 5'd14;
   localparam logic [STATE_W-1:0] S_EXC_EPC   = 5'd15;
   localparam logic [STATE_W-1:0] S_EXC_RD0   = 5'd16;
   localparam logic [STATE_W-1:0] S_EXC_RD1   = 5'd17;
   localparam logic [STATE_W-1:0] S_EXC_JMP   = 5'd18;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;

   localparam logic [2:0] PCSRC_ALURES = 3'b000;
   localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
   localparam logic [2:0] PCSRC_JUMP   = 3'b010;
   localparam logic [2:0] PCSRC_OW     = 3'b011;
   localparam logic [2:0] PCSRC_EPC    = 3'b100;

   localparam logic [2:0] IORD_PC     = 3'b000;
   localparam logic [2:0] IORD_ALUOUT = 3'b001;
   localparam logic [2:0] IORD_VEC    = 3'b100;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_4     = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;

   localparam logic [3:0] M2R_ALUOUT = 4'b0000;
   localparam logic [3:0] M2R_MDR    = 4'b0001;

   localparam logic CAUSE_OPC = 1'b0;
   localparam logic CAUSE_OVF = 1'b1;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       eq_or_ne;
      logic [2:0] pc_src;
      logic [2:0] iord;
      logic       mem_wr;
      logic       wd_src;
      logic       mdr_load;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [3:0] mem_to_reg;
      logic       rega_load;
      logic       regb_load;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       aluout_load;
      logic       aluo_src;
      logic       epc_write;
      logic       store;
      logic       two_bytes;
   } ctrl_t;

   // Control word for a state; anything not set stays 0.
   function automatic ctrl_t cu_decode(input logic [STATE_W-1:0] st,
                                       input logic [5:0] opc,
                                       input logic [5:0] fn);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH0, S_FETCH1: begin
            c.iord      = IORD_PC;
            c.alu_src_a = 1'b0;
            c.alu_src_b = SRCB_4;
            c.alu_op    = ALU_ADD;
         end
         S_FETCH2: begin
            c.ir_write = 1'b1;
            c.pc_write = 1'b1;
            c.pc_src   = PCSRC_ALURES;
         end
         S_DECODE: begin
            c.rega_load   = 1'b1;
            c.regb_load   = 1'b1;
            c.alu_src_b   = SRCB_IMMSH;
            c.alu_op      = ALU_ADD;
            c.aluout_load = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a   = 1'b1;
            c.alu_src_b   = SRCB_B;
            c.aluout_load = 1'b1;
            case (fn)
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               default: c.alu_op = 3'b000;
            endcase
         end
         S_R_WB: begin
            c.reg_dst    = DST_RD;
            c.mem_to_reg = M2R_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_ADDI_EXEC, S_MEM_ADDR: begin
            c.alu_src_a   = 1'b1;
            c.alu_src_b   = SRCB_IMM;
            c.alu_op      = ALU_ADD;
            c.aluout_load = 1'b1;
         end
         S_ADDI_WB: begin
            c.reg_dst   = DST_RT;
            c.reg_write = 1'b1;
         end
         S_LW_RD0: c.iord = IORD_ALUOUT;
         S_LW_RD1: begin
            c.iord     = IORD_ALUOUT;
            c.mdr_load = 1'b1;
         end
         S_LW_WB: begin
            c.reg_dst    = DST_RT;
            c.mem_to_reg = M2R_MDR;
            c.reg_write  = 1'b1;
         end
         S_SW_WR: begin
            c.iord   = IORD_ALUOUT;
            c.wd_src = 1'b0;
            c.mem_wr = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_B;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_src        = PCSRC_ALUOUT;
            c.eq_or_ne      = opc[0];
         end
         S_JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = PCSRC_JUMP;
         end
         S_EXC_EPC: begin
            c.alu_src_a = 1'b0;
            c.alu_src_b = SRCB_4;
            c.alu_op    = ALU_SUB;
            c.epc_write = 1'b1;
         end
         S_EXC_RD0: c.iord = IORD_VEC;
         S_EXC_RD1: begin
            c.iord     = IORD_VEC;
            c.mdr_load = 1'b1;
         end
         S_EXC_JMP: begin
            c.store     = 1'b0;
            c.two_bytes = 1'b0;
            c.pc_src    = PCSRC_OW;
            c.pc_write  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and the EPC exception path; the control word is registered from the next state.
module control_unit
   import cu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       overflow,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       EQorNE,
   output logic [2:0] PCSrc,
   output logic [2:0] IorD,
   output logic       MemRead_Write,
   output logic       WDSrc,
   output logic       MDR,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [3:0] MemtoReg,
   output logic       RegALoad,
   output logic       RegBLoad,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ALUOutLoad,
   output logic       ALUOSrc,
   output logic       EPCWrite,
   output logic       Store,
   output logic       TwoBytes,
   output logic [4:0] state_o
);

   logic [STATE_W-1:0] state_q, state_d;
   logic               exc_cause_q, exc_cause_d;
   logic               run_q;
   ctrl_t              ctrl_q, ctrl_d;

   // run_q holds FETCH0 for one cycle after reset so its control word can be loaded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_FETCH0;
         exc_cause_q <= CAUSE_OPC;
         run_q       <= 1'b0;
         ctrl_q      <= '0;
      end else begin
         state_q     <= state_d;
         exc_cause_q <= exc_cause_d;
         run_q       <= 1'b1;
         ctrl_q      <= ctrl_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      exc_cause_d = exc_cause_q;
      if (!run_q) begin
         state_d = S_FETCH0;
      end else begin
         case (state_q)
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_RTYPE: begin
                     if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
                        state_d = S_R_EXEC;
                     end else begin
                        state_d     = S_EXC_EPC;
                        exc_cause_d = CAUSE_OPC;
                     end
                  end
                  OP_ADDI:        state_d = S_ADDI_EXEC;
                  OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                  OP_BEQ, OP_BNE: state_d = S_BRANCH;
                  OP_J:           state_d = S_JUMP;
                  default: begin
                     state_d     = S_EXC_EPC;
                     exc_cause_d = CAUSE_OPC;
                  end
               endcase
            end
            S_R_EXEC: begin
               if (overflow && funct != FN_AND) begin
                  state_d     = S_EXC_EPC;
                  exc_cause_d = CAUSE_OVF;
               end else begin
                  state_d = S_R_WB;
               end
            end
            S_ADDI_EXEC: begin
               if (overflow) begin
                  state_d     = S_EXC_EPC;
                  exc_cause_d = CAUSE_OVF;
               end else begin
                  state_d = S_ADDI_WB;
               end
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_LW_RD0 : S_SW_WR;
            S_LW_RD0:   state_d = S_LW_RD1;
            S_LW_RD1:   state_d = S_LW_WB;
            S_EXC_EPC:  state_d = S_EXC_RD0;
            S_EXC_RD0:  state_d = S_EXC_RD1;
            S_EXC_RD1:  state_d = S_EXC_JMP;
            default:    state_d = S_FETCH0;
         endcase
      end
      ctrl_d = cu_decode(state_d, opcode, funct);
   end

   assign PCWrite       = ctrl_q.pc_write;
   assign PCWriteCond   = ctrl_q.pc_write_cond;
   assign EQorNE        = ctrl_q.eq_or_ne;
   assign PCSrc         = ctrl_q.pc_src;
   assign IorD          = ctrl_q.iord;
   assign MemRead_Write = ctrl_q.mem_wr;
   assign WDSrc         = ctrl_q.wd_src;
   assign MDR           = ctrl_q.mdr_load;
   assign IRWrite       = ctrl_q.ir_write;
   assign RegWrite      = ctrl_q.reg_write;
   assign RegDst        = ctrl_q.reg_dst;
   assign MemtoReg      = ctrl_q.mem_to_reg;
   assign RegALoad      = ctrl_q.rega_load;
   assign RegBLoad      = ctrl_q.regb_load;
   assign ALUSrcA       = ctrl_q.alu_src_a;
   assign ALUSrcB       = ctrl_q.alu_src_b;
   assign ALUOp         = ctrl_q.alu_op;
   assign ALUOutLoad    = ctrl_q.aluout_load;
   assign ALUOSrc       = ctrl_q.aluo_src;
   assign EPCWrite      = ctrl_q.epc_write;
   assign Store         = ctrl_q.store;
   assign TwoBytes      = ctrl_q.two_bytes;
   assign state_o       = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: state sequences and key control outputs
// per instruction class, exceptions and reset behaviour.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       overflow;
   logic       PCWrite, PCWriteCond, EQorNE;
   logic [2:0] PCSrc, IorD;
   logic       MemRead_Write, WDSrc, MDR, IRWrite, RegWrite;
   logic [1:0] RegDst;
   logic [3:0] MemtoReg;
   logic       RegALoad, RegBLoad, ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOp;
   logic       ALUOutLoad, ALUOSrc, EPCWrite, Store, TwoBytes;
   logic [4:0] state_o;
   logic [32:0] all_outs;

   int checks   = 0;
   int failures = 0;

   control_unit dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .overflow(overflow),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .EQorNE(EQorNE), .PCSrc(PCSrc),
      .IorD(IorD), .MemRead_Write(MemRead_Write), .WDSrc(WDSrc), .MDR(MDR),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegALoad(RegALoad), .RegBLoad(RegBLoad), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ALUOutLoad(ALUOutLoad), .ALUOSrc(ALUOSrc), .EPCWrite(EPCWrite),
      .Store(Store), .TwoBytes(TwoBytes), .state_o(state_o)
   );

   assign all_outs = {PCWrite, PCWriteCond, EQorNE, PCSrc, IorD, MemRead_Write, WDSrc,
                      MDR, IRWrite, RegWrite, RegDst, MemtoReg, RegALoad, RegBLoad,
                      ALUSrcA, ALUSrcB, ALUOp, ALUOutLoad, ALUOSrc, EPCWrite, Store,
                      TwoBytes};

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b0; opcode = 6'h00; funct = 6'h20; overflow = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (state_o !== 5'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
      checks++; if (all_outs !== 33'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", all_outs); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (state_o !== 5'd0 || IorD !== 3'b000 || ALUOp !== 3'b001 || ALUSrcB !== 2'b01)
         begin failures++; $display("FAIL first_fetch got st=%0d iord=%b aluop=%b srcb=%b exp st=0 iord=000 aluop=001 srcb=01", state_o, IorD, ALUOp, ALUSrcB); end
      // drive into the middle of an lw, then reset again
      opcode = 6'h23;
      repeat (5) @(negedge clk);
      checks++; if (state_o !== 5'd9) begin failures++; $display("FAIL pre_reset_state got=%0d exp=9", state_o); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (state_o !== 5'd0 || all_outs !== 33'd0)
         begin failures++; $display("FAIL midreset got st=%0d outs=%h exp st=0 outs=0", state_o, all_outs); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (state_o !== 5'd0 || ALUSrcB !== 2'b01)
         begin failures++; $display("FAIL midreset_refetch got st=%0d srcb=%b exp st=0 srcb=01", state_o, ALUSrcB); end
   endtask

   task automatic test_add();
      logic [4:0] exp_s [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd0};
      opcode = 6'h00; funct = 6'h20; overflow = 1'b0;
      for (int i = 0; i < 7; i++) begin
         checks++; if (state_o !== exp_s[i]) begin failures++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, state_o, exp_s[i]); end
         checks++; if (RegWrite !== (i == 5)) begin failures++; $display("FAIL add_regwrite[%0d] got=%b exp=%b", i, RegWrite, (i == 5)); end
         if (i == 4) begin
            checks++; if (ALUOp !== 3'b001 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00)
               begin failures++; $display("FAIL add_exec got aluop=%b srca=%b srcb=%b exp 001 1 00", ALUOp, ALUSrcA, ALUSrcB); end
         end
         if (i == 5) begin
            checks++; if (RegDst !== 2'b01) begin failures++; $display("FAIL add_regdst got=%b exp=01", RegDst); end
         end
         if (i < 6) @(negedge clk);
      end
   endtask

   task automatic test_lw();
      logic [4:0] exp_s [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11, 5'd0};
      opcode = 6'h23; overflow = 1'b0;
      for (int i = 0; i < 9; i++) begin
         checks++; if (state_o !== exp_s[i]) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state_o, exp_s[i]); end
         checks++; if (MDR !== (i == 6)) begin failures++; $display("FAIL lw_mdr[%0d] got=%b exp=%b", i, MDR, (i == 6)); end
         if (i == 5) begin
            checks++; if (IorD !== 3'b001) begin failures++; $display("FAIL lw_iord got=%b exp=001", IorD); end
         end
         if (i == 7) begin
            checks++; if (MemtoReg !== 4'b0001 || RegDst !== 2'b00 || RegWrite !== 1'b1)
               begin failures++; $display("FAIL lw_wb got m2r=%b dst=%b rw=%b exp 0001 00 1", MemtoReg, RegDst, RegWrite); end
         end
         if (i < 8) @(negedge clk);
      end
   endtask

   task automatic test_sw();
      logic [4:0] exp_s [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd12, 5'd0};
      opcode = 6'h2B; overflow = 1'b0;
      for (int i = 0; i < 7; i++) begin
         checks++; if (state_o !== exp_s[i]) begin failures++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state_o, exp_s[i]); end
         checks++; if (MemRead_Write !== (i == 5)) begin failures++; $display("FAIL sw_memwr[%0d] got=%b exp=%b", i, MemRead_Write, (i == 5)); end
         checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL sw_regwrite[%0d] got=%b exp=0", i, RegWrite); end
         if (i == 5) begin
            checks++; if (IorD !== 3'b001) begin failures++; $display("FAIL sw_iord got=%b exp=001", IorD); end
         end
         if (i < 6) @(negedge clk);
      end
   endtask

   task automatic test_branch_jump();
      logic [4:0] exp_b [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd13, 5'd0};
      logic [4:0] exp_j [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd14, 5'd0};
      opcode = 6'h05; overflow = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++; if (state_o !== exp_b[i]) begin failures++; $display("FAIL bne_state[%0d] got=%0d exp=%0d", i, state_o, exp_b[i]); end
         if (i == 4) begin
            checks++; if (PCWriteCond !== 1'b1 || EQorNE !== 1'b1 || PCSrc !== 3'b001 || ALUOp !== 3'b010)
               begin failures++; $display("FAIL bne_ctrl got pwc=%b eqne=%b pcsrc=%b aluop=%b exp 1 1 001 010", PCWriteCond, EQorNE, PCSrc, ALUOp); end
         end
         if (i < 5) @(negedge clk);
      end
      opcode = 6'h04;
      repeat (4) @(negedge clk);
      checks++; if (state_o !== 5'd13 || EQorNE !== 1'b0 || PCWriteCond !== 1'b1)
         begin failures++; $display("FAIL beq_ctrl got st=%0d eqne=%b pwc=%b exp 13 0 1", state_o, EQorNE, PCWriteCond); end
      @(negedge clk);
      opcode = 6'h02;
      for (int i = 0; i < 6; i++) begin
         checks++; if (state_o !== exp_j[i]) begin failures++; $display("FAIL j_state[%0d] got=%0d exp=%0d", i, state_o, exp_j[i]); end
         if (i == 4) begin
            checks++; if (PCWrite !== 1'b1 || PCSrc !== 3'b010)
               begin failures++; $display("FAIL j_ctrl got pcw=%b pcsrc=%b exp 1 010", PCWrite, PCSrc); end
         end
         if (i < 5) @(negedge clk);
      end
   endtask

   task automatic test_addi_overflow();
      logic [4:0] exp_s [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0};
      opcode = 6'h08; overflow = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++; if (state_o !== exp_s[i]) begin failures++; $display("FAIL addi_ovf_state[%0d] got=%0d exp=%0d", i, state_o, exp_s[i]); end
         checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL addi_ovf_regwrite[%0d] got=%b exp=0", i, RegWrite); end
         if (i == 5) begin
            checks++; if (EPCWrite !== 1'b1 || ALUOp !== 3'b010 || ALUSrcB !== 2'b01)
               begin failures++; $display("FAIL addi_ovf_epc got epcw=%b aluop=%b srcb=%b exp 1 010 01", EPCWrite, ALUOp, ALUSrcB); end
         end
         if (i == 6) begin
            checks++; if (IorD !== 3'b100 || dut.exc_cause_q !== 1'b1)
               begin failures++; $display("FAIL addi_ovf_vec got iord=%b cause=%b exp 100 1", IorD, dut.exc_cause_q); end
         end
         if (i == 7) begin
            checks++; if (MDR !== 1'b1 || IorD !== 3'b100) begin failures++; $display("FAIL addi_ovf_mdr got mdr=%b iord=%b exp 1 100", MDR, IorD); end
         end
         if (i == 8) begin
            checks++; if (PCWrite !== 1'b1 || PCSrc !== 3'b011)
               begin failures++; $display("FAIL addi_ovf_jmp got pcw=%b pcsrc=%b exp 1 011", PCWrite, PCSrc); end
         end
         if (i < 9) @(negedge clk);
      end
      overflow = 1'b0;
   endtask

   task automatic test_invalid_opcode();
      logic [4:0] exp_s [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0};
      opcode = 6'h3F; overflow = 1'b0;
      for (int i = 0; i < 9; i++) begin
         checks++; if (state_o !== exp_s[i]) begin failures++; $display("FAIL badop_state[%0d] got=%0d exp=%0d", i, state_o, exp_s[i]); end
         if (i == 5) begin
            checks++; if (IorD !== 3'b100 || dut.exc_cause_q !== 1'b0)
               begin failures++; $display("FAIL badop_vec got iord=%b cause=%b exp 100 0", IorD, dut.exc_cause_q); end
         end
         if (i < 8) @(negedge clk);
      end
      opcode = 6'h00; funct = 6'h25;
      repeat (4) @(negedge clk);
      checks++; if (state_o !== 5'd15 || EPCWrite !== 1'b1)
         begin failures++; $display("FAIL badfunct got st=%0d epcw=%b exp 15 1", state_o, EPCWrite); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      opcode = 6'h00; funct = 6'h22; overflow = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (state_o !== 5'd4 || ALUOp !== 3'b010)
         begin failures++; $display("FAIL sub_exec got st=%0d aluop=%b exp 4 010", state_o, ALUOp); end
      @(negedge clk);
      checks++; if (state_o !== 5'd15 || RegWrite !== 1'b0)
         begin failures++; $display("FAIL sub_ovf got st=%0d rw=%b exp 15 0", state_o, RegWrite); end
      repeat (4) @(negedge clk);
      funct = 6'h24;
      repeat (4) @(negedge clk);
      checks++; if (state_o !== 5'd4 || ALUOp !== 3'b011)
         begin failures++; $display("FAIL and_exec got st=%0d aluop=%b exp 4 011", state_o, ALUOp); end
      @(negedge clk);
      checks++; if (state_o !== 5'd5 || RegWrite !== 1'b1)
         begin failures++; $display("FAIL and_ignores_ovf got st=%0d rw=%b exp 5 1", state_o, RegWrite); end
      @(negedge clk);
      overflow = 1'b0;
      checks++; if (state_o !== 5'd0) begin failures++; $display("FAIL and_return got=%0d exp=0", state_o); end
   endtask

   task automatic test_reset_during_sw();
      opcode = 6'h2B; overflow = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (state_o !== 5'd12 || MemRead_Write !== 1'b1)
         begin failures++; $display("FAIL sw_pre got st=%0d memwr=%b exp 12 1", state_o, MemRead_Write); end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (state_o !== 5'd0 || all_outs !== 33'd0)
            begin failures++; $display("FAIL sw_reset[%0d] got st=%0d outs=%h exp st=0 outs=0", i, state_o, all_outs); end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (state_o !== 5'd0 || MemRead_Write !== 1'b0 || ALUOp !== 3'b001)
         begin failures++; $display("FAIL sw_after_reset got st=%0d memwr=%b aluop=%b exp 0 0 001", state_o, MemRead_Write, ALUOp); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_sw();
      test_branch_jump();
      test_addi_overflow();
      test_invalid_opcode();
      test_back_to_back();
      test_reset_during_sw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
